text_renderer: RTL

- Text-mode pixel generator between the VGA timing generator and the 8x8 character ROM (1024x8, address = {char[6:0], row[2:0]}, 1-cycle synchronous read).
- Counts active pixels and computes the text-buffer address. Turns each returned character code into a ROM address, then serialises the returned font byte MSB-first into a 1-bit pixel stream.
- Sync and enable outputs are delayed to stay aligned with the pixel stream.

---
 rtl/text_renderer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/text_renderer.sv
// Text-mode pixel pipeline: pixel counters -> text buffer -> character ROM -> serialised pixel.
// Optional blinking block cursor on character rows 6-7 when CURSOR_EN is defined.
module text_renderer #(
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  parameter int TXT_AW   = 12,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              de_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic [TXT_AW-1:0] txt_addr_o,
  input  logic [7:0]        char_i,
  output logic [9:0]        rom_ad_o,
  output logic              rom_ce_o,
  input  logic [7:0]        rom_dout_i,
`ifdef CURSOR_EN
  input  logic [6:0]        cur_col_i,
  input  logic [4:0]        cur_row_i,
`endif
  output logic              pix_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o
);

  localparam bit        SYNC_IDLE = !SYNC_POL;
  localparam logic [9:0] COLS_W   = 10'(COLS);
  localparam logic [9:0] ROWS_W   = 10'(ROWS);

  logic [9:0] px, py;
  logic       de_prev;
  logic       vs_act;
  logic       cur_hit;
  logic       oob_hit;

  assign vs_act  = (vsync_i == SYNC_POL);
  assign oob_hit = ({3'b000, px[9:3]} >= COLS_W) || ({3'b000, py[9:3]} >= ROWS_W);

  // Counters saturate instead of wrapping; vsync wins over the end-of-line step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      px      <= '0;
      py      <= '0;
      de_prev <= 1'b0;
    end else begin
      de_prev <= de_i;
      if (de_i) begin
        if (px != 10'h3FF) px <= px + 10'd1;
      end else if (de_prev) begin
        px <= '0;
      end
      if (vs_act) py <= '0;
      else if (!de_i && de_prev && py != 10'h3FF) py <= py + 10'd1;
    end
  end

`ifdef CURSOR_EN
  logic [4:0] frame_cnt;
  logic       vs_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_cnt <= '0;
      vs_prev   <= SYNC_IDLE;
    end else begin
      vs_prev <= vsync_i;
      if (vs_act && (vs_prev != SYNC_POL)) frame_cnt <= frame_cnt + 5'd1;
    end
  end

  assign cur_hit = frame_cnt[4] && (px[9:3] == cur_col_i) &&
                   (py[9:3] == {2'b00, cur_row_i}) && (py[2:1] == 2'b11);
`else
  assign cur_hit = 1'b0;
`endif

  logic [2:0] x1, y1, x2;
  logic       de1, hs1, vs1, oob1, cur1;
  logic       de2, hs2, vs2, oob2, cur2, inv2;
  logic [7:0] sh;
  logic       bit3, de3, hs3, vs3, oob3, cur3, inv3;

  // Four-stage pipeline; the sync/enable copies ride alongside the pixel data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      txt_addr_o <= '0;
      x1 <= '0; y1 <= '0; de1 <= 1'b0; hs1 <= SYNC_IDLE; vs1 <= SYNC_IDLE;
      oob1 <= 1'b0; cur1 <= 1'b0;
      rom_ad_o <= '0; rom_ce_o <= 1'b0;
      x2 <= '0; de2 <= 1'b0; hs2 <= SYNC_IDLE; vs2 <= SYNC_IDLE;
      oob2 <= 1'b0; cur2 <= 1'b0; inv2 <= 1'b0;
      sh <= '0; bit3 <= 1'b0; de3 <= 1'b0; hs3 <= SYNC_IDLE; vs3 <= SYNC_IDLE;
      oob3 <= 1'b0; cur3 <= 1'b0; inv3 <= 1'b0;
      pix_o <= 1'b0; de_o <= 1'b0; hsync_o <= SYNC_IDLE; vsync_o <= SYNC_IDLE;
    end else begin
      txt_addr_o <= TXT_AW'(17'(py[9:3]) * 17'(COLS) + 17'(px[9:3]));
      x1   <= px[2:0];
      y1   <= py[2:0];
      de1  <= de_i;
      hs1  <= hsync_i;
      vs1  <= vsync_i;
      oob1 <= oob_hit;
      cur1 <= cur_hit;

      rom_ad_o <= {char_i[6:0], y1};
      rom_ce_o <= de1;
      inv2 <= char_i[7];
      x2   <= x1;
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      oob2 <= oob1;
      cur2 <= cur1;

      // A fresh font byte is taken at the first pixel of every character cell.
      if (x2 == 3'd0) begin
        sh   <= {rom_dout_i[6:0], 1'b0};
        bit3 <= rom_dout_i[7];
      end else begin
        sh   <= {sh[6:0], 1'b0};
        bit3 <= sh[7];
      end
      inv3 <= inv2;
      de3  <= de2;
      hs3  <= hs2;
      vs3  <= vs2;
      oob3 <= oob2;
      cur3 <= cur2;

      pix_o   <= de3 & ~oob3 & (cur3 | (bit3 ^ inv3));
      de_o    <= de3;
      hsync_o <= hs3;
      vsync_o <= vs3;
    end
  end

endmodule
